// File: rtl/ss_pkg.sv
// Shared types and width constants for the save-state sequencer.
package ss_pkg;

    // Width of the slot selector; four save slots.
    localparam int SLOT_W = 2;

    // Sequencer states. ABORT is only reachable when the watchdog is built in.
    typedef enum logic [2:0] {
        IDLE,
        PAUSE,
        XFER,
        RESUME,
        ABORT
    } ss_state_t;

    // Word address width: {slot, offset}.
    function automatic int addr_w(input int slot_words_log2);
        return slot_words_log2 + SLOT_W;
    endfunction

endpackage

// File: rtl/savestate_sequencer_if.sv
// Core-pause handshake and word-transfer bus between the save-state
// sequencer (master) and the core/storage side (slave).
interface savestate_sequencer_if #(
    parameter int SLOT_WORDS_LOG2 = 10
);
    logic                                       pause_req;
    logic                                       pause_ack;
    logic                                       mem_req;
    logic                                       mem_we;
    logic [ss_pkg::addr_w(SLOT_WORDS_LOG2)-1:0] mem_addr;
    logic                                       mem_ack;

    modport master (
        output pause_req, mem_req, mem_we, mem_addr,
        input  pause_ack, mem_ack
    );

    modport slave (
        input  pause_req, mem_req, mem_we, mem_addr,
        output pause_ack, mem_ack
    );
endinterface

// File: rtl/ss_watchdog.sv
// Stall watchdog for the save-state sequencer. Counts cycles while armed and
// flags expiry when the counter reaches all-ones. Built only with SS_TIMEOUT_EN.
module ss_watchdog #(
    parameter int TIMEOUT_BITS = 24
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    input  logic clear,
    output logic expired
);
    logic [TIMEOUT_BITS-1:0] count_q;

    // Count while armed; state entry, a word ack or leaving the armed states restarts the window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clear || !run) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = run && (count_q == '1);
endmodule

// File: rtl/savestate_sequencer.sv
// Save-state sequencer: pauses the core, moves one slot of words to or from
// storage, then resumes the core. Optional watchdog enabled by defining
// SS_TIMEOUT_EN; without it ABORT is unreachable and error is tied low.
module savestate_sequencer
    import ss_pkg::*;
#(
    parameter int SLOT_WORDS_LOG2 = 10,
    parameter int TIMEOUT_BITS    = 24
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ss_save,
    input  logic                 ss_load,
    input  logic [SLOT_W-1:0]    slot,
    savestate_sequencer_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic                 rejected
);
    ss_state_t                  state_q;
    logic [SLOT_W-1:0]          slot_q;
    logic [SLOT_WORDS_LOG2-1:0] offset_q;
    logic                       pause_req_q;
    logic                       mem_req_q;
    logic                       mem_we_q;
    logic                       done_q;
    logic                       rejected_q;

    logic request;
    logic word_ack;
    logic last_word;
    logic wd_expired;

    assign request   = ss_save | ss_load;
    // An ack only counts while a word is actually being requested.
    assign word_ack  = (state_q == XFER) && mem_req_q && bus.mem_ack;
    // The final word of the slot; the offset never wraps into the next slot.
    assign last_word = (offset_q == '1);

`ifdef SS_TIMEOUT_EN
    logic wd_run;
    logic wd_clear;
    logic error_q;

    assign wd_run   = (state_q == PAUSE) || (state_q == XFER);
    assign wd_clear = word_ack || ((state_q == PAUSE) && bus.pause_ack);

    ss_watchdog #(
        .TIMEOUT_BITS(TIMEOUT_BITS)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (wd_run),
        .clear   (wd_clear),
        .expired (wd_expired)
    );

    assign error = error_q;
`else
    assign wd_expired = 1'b0;
    // No watchdog: error is always 0 (the comparison keeps TIMEOUT_BITS referenced).
    assign error = (TIMEOUT_BITS < 0);
`endif

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            slot_q      <= '0;
            offset_q    <= '0;
            pause_req_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            done_q      <= 1'b0;
            rejected_q  <= 1'b0;
`ifdef SS_TIMEOUT_EN
            error_q     <= 1'b0;
`endif
        end else begin
            done_q     <= 1'b0;
            rejected_q <= 1'b0;
`ifdef SS_TIMEOUT_EN
            error_q    <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    // Save wins a simultaneous request; the load is silently dropped.
                    if (request) begin
                        slot_q      <= slot;
                        mem_we_q    <= ss_save;
                        offset_q    <= '0;
                        pause_req_q <= 1'b1;
                        state_q     <= PAUSE;
                    end
                end
                PAUSE: begin
                    rejected_q <= request;
                    if (bus.pause_ack) begin
                        mem_req_q <= 1'b1;
                        state_q   <= XFER;
                    end else if (wd_expired) begin
                        pause_req_q <= 1'b0;
                        state_q     <= ABORT;
`ifdef SS_TIMEOUT_EN
                        error_q     <= 1'b1;
`endif
                    end
                end
                XFER: begin
                    rejected_q <= request;
                    if (word_ack) begin
                        if (last_word) begin
                            mem_req_q   <= 1'b0;
                            pause_req_q <= 1'b0;
                            state_q     <= RESUME;
                        end else begin
                            offset_q <= offset_q + 1'b1;
                        end
                    end else if (wd_expired) begin
                        mem_req_q   <= 1'b0;
                        pause_req_q <= 1'b0;
                        state_q     <= ABORT;
`ifdef SS_TIMEOUT_EN
                        error_q     <= 1'b1;
`endif
                    end
                end
                RESUME: begin
                    rejected_q <= request;
                    if (!bus.pause_ack) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                ABORT: begin
                    rejected_q <= request;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.pause_req = pause_req_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = {slot_q, offset_q};
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign rejected      = rejected_q;
endmodule

// File: tb/tb_savestate_sequencer.sv
// Self-checking bench for savestate_sequencer. Core/storage responder with a
// scoreboard of expected word transfers; the timeout scenario runs only when
// SS_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_savestate_sequencer;
    import ss_pkg::*;

    localparam int SWL = 2;
    localparam int TB  = 4;
    localparam int AW  = SWL + SLOT_W;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
    } xfer_t;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        ss_save = 1'b0;
    logic        ss_load = 1'b0;
    logic [1:0]  slot    = 2'd0;
    logic        busy;
    logic        done;
    logic        error;
    logic        rejected;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int rej_cnt  = 0;
    int err_cnt  = 0;
    int ack_cnt  = 0;

    int pause_delay  = 2;
    bit pause_en     = 1'b1;
    int ack_period   = 1;
    int pcnt         = 0;
    int acnt         = 0;
    bit spurious_ack = 1'b0;

    xfer_t exp_q[$];

    savestate_sequencer_if #(.SLOT_WORDS_LOG2(SWL)) bus ();

    savestate_sequencer #(
        .SLOT_WORDS_LOG2(SWL),
        .TIMEOUT_BITS   (TB)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ss_save  (ss_save),
        .ss_load  (ss_load),
        .slot     (slot),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .rejected (rejected)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Core and storage model plus pulse counters, all on the falling edge.
    always @(negedge clk) begin
        logic ack_n;
        ack_n = 1'b0;
        if (!reset_n) begin
            bus.pause_ack = 1'b0;
            bus.mem_ack   = 1'b0;
            pcnt = 0;
            acnt = 0;
        end else begin
            if (done)     done_cnt++;
            if (rejected) rej_cnt++;
            if (error)    err_cnt++;
            if (bus.pause_req) begin
                if (pause_en && !bus.pause_ack) begin
                    pcnt++;
                    if (pcnt >= pause_delay) bus.pause_ack = 1'b1;
                end
            end else begin
                bus.pause_ack = 1'b0;
                pcnt = 0;
            end
            if (bus.mem_req) begin
                if (exp_q.size() == 0) begin
                    chk("xfer_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("mem_addr", 32'(bus.mem_addr), 32'(exp_q[0].addr));
                    chk("mem_we", 32'(bus.mem_we), 32'(exp_q[0].we));
                    if (acnt == ack_period - 1) begin
                        ack_n = 1'b1;
                        acnt  = 0;
                        void'(exp_q.pop_front());
                        ack_cnt++;
                    end else begin
                        acnt++;
                    end
                end
            end else begin
                acnt = 0;
            end
            bus.mem_ack = ack_n | spurious_ack;
        end
    end

    task automatic push_slot(input logic [1:0] s, input bit we);
        for (int i = 0; i < 4; i++) begin
            xfer_t t;
            t.addr = {s, i[1:0]};
            t.we   = we;
            exp_q.push_back(t);
        end
    endtask

    // Called at negedge+1; returns one cycle later with the request removed.
    task automatic request(input bit sv, input bit ld, input logic [1:0] s);
        ss_save = sv;
        ss_load = ld;
        slot    = s;
        @(negedge clk); #1;
        ss_save = 1'b0;
        ss_load = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string tag);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        chk(tag, 32'(done_cnt != d0), 32'd1);
    endtask

    task automatic wait_mem_req(input string tag);
        int n;
        n = 0;
        while (!bus.mem_req && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        chk(tag, 32'(bus.mem_req), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int d0;
        int a0;
        int r0;
        int e0;
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_pause_req", 32'(bus.pause_req), 32'd0);
        chk("rst_mem_req",   32'(bus.mem_req),   32'd0);
        chk("rst_mem_we",    32'(bus.mem_we),    32'd0);
        chk("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
        chk("rst_busy",      32'(busy),          32'd0);
        chk("rst_done",      32'(done),          32'd0);
        chk("rst_error",     32'(error),         32'd0);
        chk("rst_rejected",  32'(rejected),      32'd0);
        reset_n = 1'b1;
        @(negedge clk); #1;

        // Save slot 2, ack every cycle, slot input changed after acceptance
        ack_period = 1;
        d0 = done_cnt;
        a0 = ack_cnt;
        push_slot(2'd2, 1'b1);
        request(1'b1, 1'b0, 2'd2);
        chk("save_pause_req", 32'(bus.pause_req), 32'd1);
        chk("save_busy",      32'(busy),          32'd1);
        slot = 2'd3;
        spurious_ack = 1'b1;
        @(negedge clk); #1;
        spurious_ack = 1'b0;
        wait_done(d0, "save_done");
        chk("save_done_pulse",    32'(done),          32'd1);
        chk("save_pause_ack_low", 32'(bus.pause_ack), 32'd0);
        @(negedge clk); #1;
        chk("save_done_clear", 32'(done),        32'd0);
        chk("save_idle_busy",  32'(busy),        32'd0);
        chk("save_sb_empty",   exp_q.size(),     32'd0);
        chk("save_acks",       ack_cnt - a0,     32'd4);

        // Load slot 1, ack every third cycle
        ack_period = 3;
        d0 = done_cnt;
        a0 = ack_cnt;
        r0 = rej_cnt;
        push_slot(2'd1, 1'b0);
        request(1'b0, 1'b1, 2'd1);
        wait_done(d0, "load_done");
        @(negedge clk); #1;
        chk("load_sb_empty", exp_q.size(),  32'd0);
        chk("load_acks",     ack_cnt - a0,  32'd4);
        chk("load_no_rej",   rej_cnt - r0,  32'd0);

        // Simultaneous save+load, then a load during XFER
        ack_period = 3;
        d0 = done_cnt;
        r0 = rej_cnt;
        push_slot(2'd3, 1'b1);
        request(1'b1, 1'b1, 2'd3);
        chk("both_no_rej", 32'(rejected), 32'd0);
        wait_mem_req("both_mem_req");
        request(1'b0, 1'b1, 2'd0);
        chk("xfer_rej_pulse", 32'(rejected), 32'd1);
        @(negedge clk); #1;
        chk("xfer_rej_clear", 32'(rejected), 32'd0);
        wait_done(d0, "both_done");
        @(negedge clk); #1;
        chk("both_sb_empty", exp_q.size(), 32'd0);
        chk("both_rej_cnt",  rej_cnt - r0, 32'd1);

        // Reset during XFER at offset 2
        ack_period = 2;
        push_slot(2'd0, 1'b1);
        request(1'b1, 1'b0, 2'd0);
        n = 0;
        while (!(bus.mem_req && bus.mem_addr[1:0] == 2'd2) && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        chk("mid_offset2", 32'(bus.mem_req && bus.mem_addr[1:0] == 2'd2), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_outputs",
            32'({bus.pause_req, bus.mem_req, bus.mem_we, busy, done, error, rejected}), 32'd0);
        chk("mid_rst_addr", 32'(bus.mem_addr), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        #1;
        reset_n = 1'b1;
        d0 = done_cnt;
        e0 = err_cnt;
        repeat (6) @(negedge clk);
        #1;
        chk("post_rst_no_done",  done_cnt - d0, 32'd0);
        chk("post_rst_no_error", err_cnt - e0,  32'd0);
        chk("post_rst_idle",     32'(busy),     32'd0);
        d0 = done_cnt;
        push_slot(2'd0, 1'b1);
        request(1'b1, 1'b0, 2'd0);
        wait_done(d0, "restart_done");
        @(negedge clk); #1;
        chk("restart_sb_empty", exp_q.size(), 32'd0);

`ifdef SS_TIMEOUT_EN
        // Watchdog: pause never acknowledged
        pause_en = 1'b0;
        e0 = err_cnt;
        request(1'b1, 1'b0, 2'd2);
        repeat (15) @(negedge clk);
        #1;
        chk("wd_no_error_early", 32'(error), 32'd0);
        @(negedge clk); #1;
        chk("wd_error_pulse", 32'(error),         32'd1);
        chk("wd_pause_low",   32'(bus.pause_req), 32'd0);
        chk("wd_mem_low",     32'(bus.mem_req),   32'd0);
        @(negedge clk); #1;
        chk("wd_error_clear", 32'(error), 32'd0);
        chk("wd_busy_low",    32'(busy),  32'd0);
        chk("wd_err_cnt",     err_cnt - e0, 32'd1);
        pause_en = 1'b1;
`else
        chk("error_never", 32'(err_cnt), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
